// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-generation path: mode count, sequencer
// state encoding and the one-hot mode decode used by the sequencer and shaper.
package pulse_pkg;

   localparam int NUM_MODES = 4;
   localparam int MODE_W    = 2;

   typedef enum logic {
      RUN = 1'b0,
      GAP = 1'b1
   } seq_state_t;

   function automatic logic [NUM_MODES-1:0] onehot(input logic [MODE_W-1:0] idx);
      logic [NUM_MODES-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rise_edge.sv
// Single-bit rising-edge detector. The history register resets to RESET_VAL so
// a level already high when reset releases does not count as a press.
module rise_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_level,
   output logic o_rise
);

   logic r_levelQ;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_levelQ <= RESET_VAL;
      end else begin
         r_levelQ <= i_level;
      end
   end

   assign o_rise = i_level & ~r_levelQ;

endmodule

// File: rtl/mode_sequencer.sv
// Turns debounced Next/Previous/Auto levels into the one-hot shaper enable,
// with wrap-around stepping, timed auto-cycling and a blanking gap on every change.
module mode_sequencer #(
   parameter int AUTO_TICKS = 50_000_000,
   parameter int GAP_CYCLES = 1_000
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       Next_deb,
   input  logic       Pre_deb,
   input  logic       Auto_deb,
   output logic [3:0] Enable_SW,
   output logic [1:0] Mode_Idx,
   output logic       Auto_On,
   output logic       Busy
);

   import pulse_pkg::*;

   localparam int DWELL_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
   localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_TICKS - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic w_nextEv;
   logic w_preEv;
   logic w_autoEv;
   logic w_manual;
   logic w_advance;
   logic w_change;
   logic w_stepUp;
   logic [MODE_W-1:0] w_nextIdx;

   seq_state_t           r_state;
   logic [MODE_W-1:0]    r_idx;
   logic [NUM_MODES-1:0] r_enable;
   logic                 r_autoOn;
   logic                 r_busy;
   logic [DWELL_W-1:0]   r_dwell;
   logic [GAP_W-1:0]     r_gap;

   rise_edge #(.RESET_VAL(1'b1)) u_nextEdge (
      .i_clk(sysclk), .i_rst(reset), .i_level(Next_deb), .o_rise(w_nextEv)
   );
   rise_edge #(.RESET_VAL(1'b1)) u_preEdge (
      .i_clk(sysclk), .i_rst(reset), .i_level(Pre_deb), .o_rise(w_preEv)
   );
   rise_edge #(.RESET_VAL(1'b1)) u_autoEdge (
      .i_clk(sysclk), .i_rst(reset), .i_level(Auto_deb), .o_rise(w_autoEv)
   );

   // Simultaneous Next and Pre cancel; a manual step pre-empts an auto advance.
   assign w_manual  = w_nextEv ^ w_preEv;
   assign w_advance = r_autoOn && !w_autoEv && !w_manual &&
                      (r_state == RUN) && (r_dwell == DWELL_LAST);
   assign w_change  = w_manual | w_advance;
   assign w_stepUp  = w_manual ? w_nextEv : 1'b1;
   assign w_nextIdx = w_stepUp ? (r_idx + MODE_W'(1)) : (r_idx - MODE_W'(1));

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_state  <= RUN;
         r_idx    <= '0;
         r_enable <= NUM_MODES'(1);
         r_autoOn <= 1'b0;
         r_busy   <= 1'b0;
         r_dwell  <= '0;
         r_gap    <= '0;
      end else begin
         if (w_change) begin
            r_idx <= w_nextIdx;
         end

         if (w_autoEv) begin
            r_autoOn <= ~r_autoOn;
         end else if (w_manual) begin
            r_autoOn <= 1'b0;
         end

         // Dwell only runs while settled in RUN with auto already active.
         if ((r_state == RUN) && r_autoOn && !w_autoEv && !w_change) begin
            r_dwell <= r_dwell + DWELL_W'(1);
         end else begin
            r_dwell <= '0;
         end

         case (r_state)
            RUN: begin
               if (w_change) begin
                  if (GAP_CYCLES == 0) begin
                     r_enable <= onehot(w_nextIdx);
                  end else begin
                     r_state  <= GAP;
                     r_gap    <= '0;
                     r_enable <= '0;
                     r_busy   <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (w_change) begin
                  r_gap <= '0;
               end else if (r_gap == GAP_LAST) begin
                  r_state  <= RUN;
                  r_gap    <= '0;
                  r_enable <= onehot(r_idx);
                  r_busy   <= 1'b0;
               end else begin
                  r_gap <= r_gap + GAP_W'(1);
               end
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   assign Enable_SW = r_enable;
   assign Mode_Idx  = r_idx;
   assign Auto_On   = r_autoOn;
   assign Busy      = r_busy;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer: directed walk through the stepping,
// gap, auto and reset behaviour, then random button activity against a model.
module tb_mode_sequencer;

   localparam int AT = 8;
   localparam int GC = 2;

   logic       sysclk = 1'b0;
   logic       reset;
   logic       nextDeb;
   logic       preDeb;
   logic       autoDeb;
   logic [3:0] Enable_SW;
   logic [1:0] Mode_Idx;
   logic       Auto_On;
   logic       Busy;

   int checks = 0;
   int errors = 0;

   // Reference state: mode number, auto flag, dwell count, cycles of blanking left.
   int mMode;
   int mDwell;
   int mGapLeft;
   bit mAuto;
   bit pN, pP, pA;

   mode_sequencer #(.AUTO_TICKS(AT), .GAP_CYCLES(GC)) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .Next_deb (nextDeb),
      .Pre_deb  (preDeb),
      .Auto_deb (autoDeb),
      .Enable_SW(Enable_SW),
      .Mode_Idx (Mode_Idx),
      .Auto_On  (Auto_On),
      .Busy     (Busy)
   );

   always #5 sysclk = ~sysclk;

   task automatic modelReset();
      mMode = 0; mDwell = 0; mGapLeft = 0; mAuto = 1'b0;
      pN = 1'b1; pP = 1'b1; pA = 1'b1;
   endtask

   // One rising clock edge of the behavioural model.
   task automatic modelStep();
      bit evN, evP, evA, manual, adv, change, wasAuto;
      evN = nextDeb && !pN;
      evP = preDeb  && !pP;
      evA = autoDeb && !pA;
      pN = nextDeb; pP = preDeb; pA = autoDeb;
      manual  = evN ^ evP;
      wasAuto = mAuto;
      adv     = wasAuto && !evA && !manual && (mGapLeft == 0) && (mDwell == AT - 1);
      change  = manual || adv;
      if (evA) mAuto = !mAuto;
      else if (manual) mAuto = 1'b0;
      if ((mGapLeft == 0) && wasAuto && !evA && !change) mDwell = mDwell + 1;
      else mDwell = 0;
      if (change) begin
         mMode    = (mMode + ((manual ? evN : 1'b1) ? 1 : 3)) % 4;
         mGapLeft = GC;
      end else if (mGapLeft > 0) begin
         mGapLeft = mGapLeft - 1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] en, input logic [1:0] idx,
                              input logic au, input logic bs);
      checks++;
      assert (Enable_SW === en) else begin
         errors++;
         $error("FAIL %s Enable_SW got %b want %b", tag, Enable_SW, en);
      end
      checks++;
      assert (Mode_Idx === idx) else begin
         errors++;
         $error("FAIL %s Mode_Idx got %0d want %0d", tag, Mode_Idx, idx);
      end
      checks++;
      assert (Auto_On === au) else begin
         errors++;
         $error("FAIL %s Auto_On got %b want %b", tag, Auto_On, au);
      end
      checks++;
      assert (Busy === bs) else begin
         errors++;
         $error("FAIL %s Busy got %b want %b", tag, Busy, bs);
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput(tag, (mGapLeft > 0) ? 4'b0000 : 4'(1 << mMode), 2'(mMode), mAuto, mGapLeft > 0);
   endtask

   task automatic tick(input string tag);
      @(posedge sysclk);
      modelStep();
      #1;
      checkModel(tag);
   endtask

   task automatic applyStimulus(input logic n, input logic p, input logic a, input string tag);
      nextDeb = n; preDeb = p; autoDeb = a;
      tick(tag);
   endtask

   task automatic idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      reset = 1'b1; nextDeb = 1'b0; preDeb = 1'b0; autoDeb = 1'b0;
      modelReset();
      repeat (2) @(posedge sysclk);
      #1;
      checkOutput("reset", 4'b0001, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      idle(2, "postReset");

      applyStimulus(1'b1, 1'b0, 1'b0, "next1");
      checkOutput("next1Gap0", 4'b0000, 2'd1, 1'b0, 1'b1);
      idle(1, "next1Gap");
      checkOutput("next1Gap1", 4'b0000, 2'd1, 1'b0, 1'b1);
      idle(1, "next1Done");
      checkOutput("next1Done", 4'b0010, 2'd1, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b1, 1'b0, "preTo0");
      idle(3, "preTo0Settle");
      applyStimulus(1'b0, 1'b1, 1'b0, "preWrap");
      idle(3, "preWrapSettle");
      checkOutput("preWrap", 4'b1000, 2'd3, 1'b0, 1'b0);

      applyStimulus(1'b1, 1'b0, 1'b0, "nextWrap");
      idle(3, "nextWrapSettle");
      checkOutput("nextWrap", 4'b0001, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, "nextA");
      idle(3, "nextASettle");
      checkOutput("nextA", 4'b0010, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, "nextB");
      idle(3, "nextBSettle");
      checkOutput("nextB", 4'b0100, 2'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, "nextC");
      idle(3, "nextCSettle");
      checkOutput("nextC", 4'b1000, 2'd3, 1'b0, 1'b0);

      applyStimulus(1'b1, 1'b1, 1'b0, "bothPress");
      checkOutput("bothPress", 4'b1000, 2'd3, 1'b0, 1'b0);
      idle(2, "bothRelease");

      applyStimulus(1'b1, 1'b0, 1'b0, "toZero");
      idle(3, "toZeroSettle");
      applyStimulus(1'b1, 1'b0, 1'b0, "restart1");
      idle(1, "restartMid");
      applyStimulus(1'b1, 1'b0, 1'b0, "restart2");
      checkOutput("restart2", 4'b0000, 2'd2, 1'b0, 1'b1);
      idle(1, "restartGap");
      checkOutput("restartGap", 4'b0000, 2'd2, 1'b0, 1'b1);
      idle(1, "restartDone");
      checkOutput("restartDone", 4'b0100, 2'd2, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b0, 1'b1, "autoOn");
      checkOutput("autoOn", 4'b0100, 2'd2, 1'b1, 1'b0);
      idle(AT - 1, "autoDwell");
      checkOutput("autoDwellEnd", 4'b0100, 2'd2, 1'b1, 1'b0);
      idle(1, "autoAdv1");
      checkOutput("autoAdv1", 4'b0000, 2'd3, 1'b1, 1'b1);
      idle(GC, "autoGap1");
      checkOutput("autoMode3", 4'b1000, 2'd3, 1'b1, 1'b0);
      idle(AT + GC, "autoPeriod2");
      checkOutput("autoMode0", 4'b0001, 2'd0, 1'b1, 1'b0);

      applyStimulus(1'b1, 1'b0, 1'b0, "autoExit");
      checkOutput("autoExit", 4'b0000, 2'd1, 1'b0, 1'b1);
      idle(3, "autoExitSettle");
      applyStimulus(1'b1, 1'b0, 1'b1, "autoAndNext");
      checkOutput("autoAndNext", 4'b0000, 2'd2, 1'b1, 1'b1);
      idle(5, "autoAgain");

      applyStimulus(1'b1, 1'b0, 1'b0, "preResetPress");
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("resetMidGap", 4'b0001, 2'd0, 1'b0, 1'b0);
      @(posedge sysclk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, "heldNext");
      checkOutput("heldNext", 4'b0001, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, "heldRelease");
      applyStimulus(1'b1, 1'b0, 1'b0, "repress");
      checkOutput("repress", 4'b0000, 2'd1, 1'b0, 1'b1);

      for (int i = 0; i < 800; i++) begin
         logic n, p, a;
         n = ($urandom_range(0, 3) == 0) ? ~nextDeb : nextDeb;
         p = ($urandom_range(0, 5) == 0) ? ~preDeb  : preDeb;
         a = ($urandom_range(0, 29) == 0) ? ~autoDeb : autoDeb;
         applyStimulus(n, p, a, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
